// File: rtl/conf_stream_loader_pkg.sv
// Shared controller definitions for the configuration stream path:
// loader state encoding, header field layout and half-word selection.
package conf_stream_loader_pkg;

  // Loader states; the reader walks an equivalent read/wait sequence
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DUP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Header word layout, also used by the configuration memory reader
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_BASE_W   = 16;

  // Which 16-bit half of a payload word goes onto the bus
  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

  function automatic logic [15:0] selectHalf(input logic [31:0] word, input half_e sel);
    return (sel == HALF_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/conf_stream_loader_writer.sv
// Registered 16-bit write port for the array configuration bus.
// Each strobe presents one half of a payload word at the given address.
module cfg_halfword_writer
  import conf_stream_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wrEn_i,
  input  half_e             halfSel_i,
  input  logic [31:0]       word_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              cfgWe_o,
  output logic [ADDR_W-1:0] cfgAddr_o,
  output logic [15:0]       cfgWdata_o
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;

  // Register the strobe every cycle; address/data only move on a write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= wrEn_i;
      if (wrEn_i) begin
        addr_q <= addr_i;
        data_q <= selectHalf(word_i, halfSel_i);
      end
    end
  end

  assign cfgWe_o    = we_q;
  assign cfgAddr_o  = addr_q;
  assign cfgWdata_o = data_q;

endmodule

// File: rtl/conf_stream_loader.sv
// Configuration stream sink: reads a header, then unpacks each payload
// word into two 16-bit bus writes while pacing the reader with rnready.
module conf_stream_loader
  import conf_stream_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              conf_en,
  input  logic              pdone,
  input  logic [31:0]       din,
  output logic              rnready,
  output logic              config_done,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [15:0]       cfg_wdata
);

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       hold_q, hold_d;
  logic              rnready_q;
  logic              done_q;

  logic              wrEn;
  half_e             halfSel;
  logic [31:0]       wrWord;
  logic [15:0]       hdrCount;
  logic [ADDR_W-1:0] hdrBase;

  assign hdrCount = din[HDR_CNT_LSB +: HDR_CNT_W];
  assign hdrBase  = ADDR_W'(din[HDR_BASE_LSB +: HDR_BASE_W]);

  // Next state, counters and write request; the low half comes straight
  // from din in ACC so it reaches the bus one cycle after acceptance
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    wrEn    = 1'b0;
    halfSel = HALF_LO;
    wrWord  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (conf_en & pdone) state_d = ST_HDR;
      end
      ST_HDR: begin
        count_d = hdrCount;
        addr_d  = hdrBase;
        state_d = (hdrCount == 16'd0) ? ST_DONE : ST_ACC;
      end
      ST_ACC: begin
        hold_d  = din;
        wrEn    = 1'b1;
        halfSel = HALF_LO;
        wrWord  = din;
        count_d = count_q - 16'd1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_DUP;
      end
      ST_DUP: begin
        wrEn    = 1'b1;
        halfSel = HALF_HI;
        wrWord  = hold_q;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (count_q == 16'd0) ? ST_DONE : ST_ACC;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; rnready/config_done are registered
  // from the next state so they line up with ACC and DONE cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      hold_q    <= '0;
      rnready_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      rnready_q <= (state_d == ST_ACC);
      done_q    <= (state_d == ST_DONE);
    end
  end

  cfg_halfword_writer #(
    .ADDR_W(ADDR_W)
  ) u_writer (
    .clk       (clk),
    .resetn    (resetn),
    .wrEn_i    (wrEn),
    .halfSel_i (halfSel),
    .word_i    (wrWord),
    .addr_i    (addr_q),
    .cfgWe_o   (cfg_we),
    .cfgAddr_o (cfg_addr),
    .cfgWdata_o(cfg_wdata)
  );

  assign rnready     = rnready_q;
  assign config_done = done_q;

endmodule

// File: tb/tb_conf_stream_loader.sv
// Self-checking bench: plays the configuration reader and compares the
// loader's bus writes and handshakes against a cycle schedule model.
module tb_conf_stream_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        conf_en;
  logic        pdone;
  logic [31:0] din;
  logic        rnready;
  logic        config_done;
  logic        cfg_we;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_wdata;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] payload[$];

  conf_stream_loader #(.ADDR_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .conf_en    (conf_en),
    .pdone      (pdone),
    .din        (din),
    .rnready    (rnready),
    .config_done(config_done),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // Set inputs just after a rising edge, return at the following falling edge
  task automatic applyStimulus(input logic en, input logic pd, input logic [31:0] d);
    @(posedge clk);
    #1;
    conf_en = en;
    pdone   = pd;
    din     = d;
    @(negedge clk);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".we"},      32'(cfg_we),      32'd0);
    checkOutput({tag, ".done"},    32'(config_done), 32'd0);
    checkOutput({tag, ".rnready"}, 32'(rnready),     32'd0);
    checkOutput({tag, ".addr"},    32'(cfg_addr),    32'd0);
    checkOutput({tag, ".wdata"},   32'(cfg_wdata),   32'd0);
  endtask

  // Idle cycles never present conf_en and pdone high together
  task automatic idleCycles(input int n);
    logic en, pd;
    for (int i = 0; i < n; i++) begin
      en = 1'($urandom);
      pd = en ? 1'b0 : 1'($urandom);
      applyStimulus(en, pd, $urandom);
      checkZero("idle");
    end
  endtask

  // Asynchronous reset entered mid-cycle, held 3 cycles with toggling inputs
  task automatic doReset();
    resetn = 1'b0;
    #1;
    checkZero("rst_async");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom);
      checkZero("rst_hold");
    end
    conf_en = 1'b0;
    pdone   = 1'b0;
    resetn  = 1'b1;
  endtask

  // One load: the reader sends the header one cycle after the start
  // handshake, then each payload word twice (accepted, then repeated).
  // Expected behaviour per cycle c after the handshake cycle:
  //   rnready high on the first showing of each word (c = 2, 4, ...),
  //   write j (0..2N-1) appears at c = 3+j, config_done from c = 2N+2.
  task automatic runLoad(input logic [15:0] base, input int n, input int abortAt, input int extra);
    logic [31:0] hdr;
    logic [31:0] d;
    logic [31:0] expData;
    logic [15:0] expAddr;
    logic        en, pd, expRn, expWe, expDone;
    int          total, k, j;
    hdr   = {base, 16'(n)};
    total = 2 * n + 2 + extra;
    applyStimulus(1'b1, 1'b1, $urandom);
    checkZero("start");
    for (int c = 1; c <= total; c++) begin
      if (c == 1) d = hdr;
      else begin
        k = (c - 2) / 2;
        d = (k < n) ? payload[k] : $urandom;
      end
      if (c > 2 * n + 2) begin
        en = 1'b1;
        pd = 1'b1;
      end else begin
        en = 1'($urandom);
        pd = 1'($urandom);
      end
      applyStimulus(en, pd, d);
      expRn   = (c >= 2) && (c % 2 == 0) && ((c - 2) / 2 < n);
      expWe   = (c >= 3) && (c - 3 < 2 * n);
      expDone = (c >= 2 * n + 2);
      checkOutput("rnready",     32'(rnready),     32'(expRn));
      checkOutput("cfg_we",      32'(cfg_we),      32'(expWe));
      checkOutput("config_done", 32'(config_done), 32'(expDone));
      if (expWe) begin
        j       = c - 3;
        k       = j / 2;
        expAddr = base + 16'(j);
        expData = (j % 2 == 1) ? {16'd0, payload[k][31:16]} : {16'd0, payload[k][15:0]};
        checkOutput("cfg_addr",  32'(cfg_addr),  32'(expAddr));
        checkOutput("cfg_wdata", 32'(cfg_wdata), expData);
      end
      if (c == abortAt) begin
        resetn = 1'b0;
        #1;
        checkZero("abort");
        applyStimulus(1'b1, 1'b1, $urandom);
        checkZero("abort_hold");
        conf_en = 1'b0;
        pdone   = 1'b0;
        resetn  = 1'b1;
        return;
      end
    end
  endtask

  task automatic fillPayload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back($urandom);
  endtask

  initial begin
    resetn  = 1'b0;
    conf_en = 1'b0;
    pdone   = 1'b0;
    din     = '0;
    @(negedge clk);
    checkZero("por");
    doReset();
    idleCycles(3);

    // Empty load: done two cycles after the handshake, no writes
    payload.delete();
    runLoad(16'h0100, 0, 0, 4);

    // Directed two-word load
    doReset();
    idleCycles(2);
    payload.delete();
    payload.push_back(32'hAAAA5555);
    payload.push_back(32'h12345678);
    runLoad(16'h0010, 2, 0, 4);

    // Address wrap across the top of the address space
    doReset();
    idleCycles(2);
    fillPayload(2);
    runLoad(16'hFFFE, 2, 0, 3);

    // Reset right after the first low-half write, then a fresh one-word load
    doReset();
    idleCycles(2);
    fillPayload(3);
    runLoad(16'(32'($urandom)), 3, 3, 0);
    idleCycles(2);
    fillPayload(1);
    runLoad(16'h0040, 1, 0, 3);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      doReset();
      idleCycles(int'($urandom_range(1, 3)));
      fillPayload(n);
      runLoad(16'(32'($urandom)), n, 0, 4);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/conf_stream_loader.md
# conf_stream_loader

Configuration-stream sink on the global controller side of the TCPA configuration path. It consumes the 32-bit word stream from the configuration memory reader (`din`, the reader's `dout`) and paces it with `rnready`. It unpacks each payload word into two 16-bit writes on the array configuration bus, then raises `config_done` to terminate the reader. It mirrors the reader's read/wait sequence so that stalled (repeated) words are never written twice.

## Interface
- `ADDR_W`, 16, width of `cfg_addr`; address arithmetic wraps modulo 2^ADDR_W.
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `conf_en`  in  1  configuration enable; shared with the reader.
- `pdone`  in  1  previous-phase done; shared with the reader.
- `din`  in  32  configuration word from the reader.
- `rnready`  out  1  read-not-ready to the reader; a high sample makes the reader repeat the current word once.
- `config_done`  out  1  load complete; sticky until reset.
- `cfg_we`  out  1  configuration bus write strobe.
- `cfg_addr`  out  ADDR_W  write address.
- `cfg_wdata`  out  16  write data.

## Operation
- Stream format:
  - Word 0 is the header: `[15:0]` = payload count N (0..65535), `[31:16]` = base address (truncated or zero-extended to ADDR_W).
  - Words 1..N are payload.
  - Payload word i writes `[15:0]` to base+2i, then `[31:16]` to base+2i+1.
- States:
  - IDLE: reset state.
  - HDR: header expected on `din` this cycle.
  - ACC: payload word valid on `din` this cycle.
  - DUP: `din` repeats the previous word; it is discarded.
  - DONE.
- Transitions:
  - IDLE→HDR when `conf_en & pdone` is sampled high.
  - HDR→ACC if N>0; HDR→DONE if N=0. The header itself produces no write.
  - ACC→DUP always, because `rnready` is high in every ACC cycle.
  - DUP→ACC while words remain; DUP→DONE after the last word has been accepted.
  - DONE is terminal until reset.
- `conf_en`/`pdone` are ignored outside IDLE. Words arriving in DONE are ignored.
- Hold register: the ACC word is captured at the end of the ACC cycle.
  - Low-half write is issued in the following (DUP) cycle.
  - High-half write is issued in the next cycle, which is ACC or DONE.
  - A new word captured at the end of that cycle overwrites the hold register only after the high half has been driven.
- Counters:
  - 16-bit remaining-word counter, loaded from the header.
  - ADDR_W address register, loaded with base and incremented after every write.
- A header with N=0 performs no writes.
- There is no error detection; every header is trusted.

## Timing
- Reset values: `rnready`=0, `config_done`=0, `cfg_we`=0, `cfg_addr`=0, `cfg_wdata`=0; state IDLE, counters 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Start handshake: `conf_en & pdone` sampled at cycle t0, header on `din` at t0+1, first payload word at t0+2.
- `rnready` is 0 in HDR and 1 in every ACC cycle.
- Throughput: one payload word per 2 cycles, matching one 16-bit write per cycle.
- For a payload word accepted at cycle t:
  - `cfg_we`=1 with the low half at t+1.
  - `cfg_we`=1 with the high half at t+2.
- Last word accepted at t: `config_done` rises at t+2, coincident with the final high-half write. The reader therefore sees `config_done` in its read state and stops with no further words.
- N=0: `config_done` rises at t0+2. The word on `din` at t0+2 is discarded.
- `resetn` low mid-load: all state and outputs return to reset values immediately and any pending write is dropped. The next load requires a fresh `conf_en & pdone`.

## Structure
- Shared controller package holds:
  - state encoding constants (IDLE, HDR, ACC, DUP, DONE);
  - header field positions (count `[15:0]`, base `[31:16]`);
  - the half-word select constants.
- The reader uses the same header layout constants.
- One natural sub-module: `cfg_halfword_writer`. It takes the hold register and address, and sequences the low/high-half writes.

## Test plan
- Reset with `resetn` low for 3 cycles, inputs toggling → all outputs 0 throughout; state IDLE after release.
- Header 0x0100_0000 (N=0) → `config_done`=1 at t0+2, `cfg_we` never 1, `rnready` never 1.
- Header 0x0010_0002, payload 0xAAAA5555, 0x12345678 → writes in order:
  - (0x0010, 0x5555)
  - (0x0011, 0xAAAA)
  - (0x0012, 0x5678)
  - (0x0013, 0x1234)
  
  Repeated words are not written; `config_done` coincides with the 0x1234 write.
- Header 0xFFFE_0002 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `resetn` pulsed low after the first low-half write of an N=3 load → outputs return to 0; a fresh start with N=1 writes correctly from base.
- After `config_done`, drive `conf_en`/`pdone` and new `din` words → no writes; `config_done` stays 1.
